// File: rtl/store_lane_aligner_if.sv
// Store request / bus-side bundle for store_lane_aligner.
// slave is the aligner's view; master is the view of whatever drives requests
// and consumes the formatted bus word.
interface store_lane_aligner_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  inValid;
  logic                  inReady;
  logic [ADDR_W-1:0]     inAddr;
  logic [DATA_W-1:0]     inData;
  logic [1:0]            inSize;
  logic                  outValid;
  logic                  outReady;
  logic [ADDR_W-1:0]     outAddr;
  logic [DATA_W-1:0]     outData;
  logic [DATA_W/8-1:0]   outByteEn;
  logic                  misalignErr;
  logic [15:0]           storeCount;

  modport slave (
    input  inValid, inAddr, inData, inSize, outReady,
    output inReady, outValid, outAddr, outData, outByteEn, misalignErr, storeCount
  );

  modport master (
    output inValid, inAddr, inData, inSize, outReady,
    input  inReady, outValid, outAddr, outData, outByteEn, misalignErr, storeCount
  );
endinterface

// File: rtl/store_lane_aligner.sv
// MEM-stage store formatter: replicates the store operand into the addressed
// byte lanes, builds the byte-enable mask and aligns the address, then hands
// the result to the bus through a 2-entry skid buffer (1-cycle latency).
// Optional feature macro: STORE_MISALIGN_EN -- when defined, misaligned
// requests are passed through with no byte enables and misalignErr set, and
// are not counted in storeCount; otherwise the offset is forced to natural
// alignment and misalignErr stays 0.
module store_lane_aligner #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic                clk,
  input logic                reset,
  store_lane_aligner_if.slave bus
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  byte_en;
    logic              err;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  entry_t        main_q, main_d;
  entry_t        skid_q, skid_d;
  logic [15:0]   count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  entry_t        fmt_entry;
  int            sz_bytes;
  int            raw_off;
  int            lane_off;
  logic          in_xfer;
  logic          out_xfer;

  // Format the incoming request into a bus-ready entry at buffer entry.
  always_comb begin
    fmt_entry = '0;
    case (bus.inSize)
      2'd0:    sz_bytes = 1;
      2'd1:    sz_bytes = 2;
      2'd2:    sz_bytes = 4;
      default: sz_bytes = (LANES == 8) ? 8 : 4;
    endcase
    raw_off  = {{(32-OFF_W){1'b0}}, bus.inAddr[OFF_W-1:0]};
    lane_off = raw_off & ~(sz_bytes - 1);
    fmt_entry.addr = bus.inAddr;
    fmt_entry.addr[OFF_W-1:0] = '0;
    for (int i = 0; i < LANES; i++) begin
      fmt_entry.data[i*8 +: 8] = bus.inData[((i & (sz_bytes - 1)) * 8) +: 8];
      fmt_entry.byte_en[i]     = (i >= lane_off) && (i < lane_off + sz_bytes);
    end
`ifdef STORE_MISALIGN_EN
    if ((raw_off & (sz_bytes - 1)) != 0) begin
      fmt_entry.byte_en = '0;
      fmt_entry.err     = 1'b1;
    end
`endif
  end

  // Skid-buffer next state: pending entry leaves before a new one lands.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    count_d  = count_q;
    in_xfer  = bus.inValid && in_ready_q;
    out_xfer = out_valid_q && bus.outReady;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = fmt_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = fmt_entry;
        end else if (in_xfer) begin
          skid_d  = fmt_entry;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (out_xfer) begin
`ifdef STORE_MISALIGN_EN
      if (!main_q.err) begin
        count_d = count_q + 16'd1;
      end
`else
      count_d = count_q + 16'd1;
`endif
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // Register the buffer, counter and handshake flags; reset drops everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.inReady     = in_ready_q;
  assign bus.outValid    = out_valid_q;
  assign bus.outAddr     = main_q.addr;
  assign bus.outData     = main_q.data;
  assign bus.outByteEn   = main_q.byte_en;
  assign bus.misalignErr = main_q.err;
  assign bus.storeCount  = count_q;

endmodule
